// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the parametrised register file.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam int unsigned RF_XLEN_DEF  = 32;
    localparam int unsigned RF_NREGS_DEF = 32;

    // LSB of slot `port` in a packed vector of `width`-bit slots.
    function automatic int unsigned rf_slice_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: data mux, pending lookup, zero-register
// override and, with REGFILE_BYPASS_EN, the same-cycle write bypass.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN_DEF,
    parameter int unsigned NREGS    = RF_NREGS_DEF,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic             i_run,
    input  logic [XLEN-1:0]  i_mem [NREGS],
    input  logic [NREGS-1:0] i_pending,
    input  logic [AW-1:0]    i_raddr,
`ifdef REGFILE_BYPASS_EN
    input  logic             i_byp_we,
    input  logic [AW-1:0]    i_byp_waddr,
    input  logic [XLEN-1:0]  i_byp_wdata,
    input  logic             i_byp_rsv,
    input  logic [AW-1:0]    i_byp_rsv_addr,
`endif
    output logic [XLEN-1:0]  o_rdata,
    output logic             o_pending
);

    logic w_zero;

    // Select the addressed entry, then apply bypass and the forced-zero cases.
    always_comb begin
        w_zero    = (ZERO_REG != 0) && (i_raddr == '0);
        o_rdata   = i_mem[i_raddr];
        o_pending = i_pending[i_raddr];
`ifdef REGFILE_BYPASS_EN
        if (i_byp_we && (i_byp_waddr == i_raddr)) begin
            o_rdata   = i_byp_wdata;
            o_pending = i_byp_rsv && (i_byp_rsv_addr == i_raddr);
        end
`endif
        if (!i_run || w_zero) begin
            o_rdata   = '0;
            o_pending = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with pending scoreboard.
// Storage is unreset; an init sweep zeroes every entry before ready.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN_DEF,
    parameter int unsigned NREGS    = RF_NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rd_pending,
    output logic                ready
);

    rf_state_e        r_state;
    rf_state_e        w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;
    logic             w_run;
    logic             w_we_ok;
    logic             w_rsv_ok;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [XLEN-1:0]  w_mem_wdata;

    assign w_run    = (r_state == RUN);
    assign ready    = w_run;
    assign w_we_ok  = w_run && we     && !((ZERO_REG != 0) && (waddr    == '0));
    assign w_rsv_ok = w_run && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // State and sweep counter registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: sweep one entry per edge, leave INIT after the last entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            INIT: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    // Pending update: a write clears, a same-cycle reserve wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_we_ok) begin
            w_pending_nxt[waddr] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_pending_nxt[rsv_addr] = 1'b1;
        end
    end

    // Pending scoreboard register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Storage write source: the init sweep or the RUN write port.
    always_comb begin
        w_mem_we    = w_we_ok || !w_run;
        w_mem_addr  = w_run ? waddr : r_cnt;
        w_mem_wdata = w_run ? wdata : '0;
    end

    // Unreset storage so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .i_run          (w_run),
            .i_mem          (r_mem),
            .i_pending      (r_pending),
            .i_raddr        (raddr[rf_slice_lsb(p, AW) +: AW]),
`ifdef REGFILE_BYPASS_EN
            .i_byp_we       (w_we_ok),
            .i_byp_waddr    (waddr),
            .i_byp_wdata    (wdata),
            .i_byp_rsv      (w_rsv_ok),
            .i_byp_rsv_addr (rsv_addr),
`endif
            .o_rdata        (rdata[rf_slice_lsb(p, XLEN) +: XLEN]),
            .o_pending      (rd_pending[p])
        );
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-read-port integer register file for the RISC-V core, the successor to the fixed 32x32, two-read-port file. Width, depth and read-port count are configurable. Register 0 can be hardwired to zero. A per-register pending scoreboard lets the issue stage detect outstanding producers. Storage is left unreset so it can map to RAM; after reset, an init sequencer sweeps zeros into every entry before `ready` asserts.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of registers; power of two, ≥ 2
- `NRD`, 2, number of read ports, 1..4
- `ZERO_REG`, 1, when 1 entry 0 reads 0, ignores writes, never goes pending
- `AW` (localparam) = $clog2(NREGS)
- `clk`  in  1  clock; all state updates on the rising edge
- `clear`  in  1  reset, asynchronous, active-high
- `we`  in  1  write enable
- `waddr`  in  AW  write address
- `wdata`  in  XLEN  write data
- `rsv_en`  in  1  reserve request; marks `rsv_addr` pending
- `rsv_addr`  in  AW  register to reserve
- `raddr`  in  NRD*AW  packed read addresses; port p = bits [p*AW +: AW]
- `rdata`  out  NRD*XLEN  packed read data, combinational
- `rd_pending`  out  NRD  pending bit of each port's addressed register
- `ready`  out  1  init sweep complete; accepts writes and reservations

## Operation
- FSM states: INIT, RUN. `clear` forces INIT, sets the sweep counter to 0 and clears all pending bits.
- INIT:
  - Each edge writes 0 to entry `cnt` and increments `cnt`.
  - When `cnt == NREGS-1` is written, the FSM moves to RUN.
  - `we` and `rsv_en` are ignored.
  - `rdata` is forced to 0 and `rd_pending` is forced to 0.
- RUN:
  - `we` writes `wdata` to `waddr` on the edge.
  - `rsv_en` sets `pending[rsv_addr]`.
  - `we` clears `pending[waddr]`.
- Write and reserve to the same address in the same cycle: reserve wins, so pending stays 1 and the data is still written.
- With `ZERO_REG=1`, writes and reserves to address 0 are dropped. Port reads of address 0 return 0 and `rd_pending` 0.
- Reads are combinational from `raddr`. Any number of ports may address the same register.
- Storage has no reset. Contents before the end of INIT are undefined and must not be observable.

## Timing
- Reset values:
  - `ready` = 0
  - `rdata` = 0
  - `rd_pending` = 0
  - FSM = INIT, `cnt` = 0, all pending bits = 0
- Init duration: `ready` rises after exactly NREGS rising edges following `clear` deassertion.
- Write latency: data is visible on `rdata` the cycle after the write edge (without bypass).
- Pending latency: a reserve or clear is visible on `rd_pending` the cycle after its edge.
- `clear` asserted mid-RUN or mid-INIT:
  - `ready` drops immediately (asynchronously).
  - The sweep restarts from entry 0.

## Configuration
- `REGFILE_BYPASS_EN`, defined:
  - A same-cycle RUN write whose `waddr` equals a port's `raddr` (nonzero when `ZERO_REG`) drives `wdata` straight onto that port's `rdata`.
  - That port's `rd_pending` reads 0, unless the same cycle also reserves that address.
- Undefined: a read in the write cycle returns the old value and the old pending bit.

## Structure
- Package `regfile_pkg` holds:
  - the `rf_state_e` enum (INIT, RUN)
  - `RF_XLEN_DEF` = 32, `RF_NREGS_DEF` = 32
  - the packed-port slice helper function
- One sub-module, `regfile_read_port`, instantiated NRD times. It contains:
  - the address decode and data mux
  - the zero-register override
  - the optional bypass compare
  - the pending-bit lookup
- The top level holds the storage array, the pending vector, the FSM and the sweep counter.

## Test plan
- Reset, then idle: `ready` = 0 for 32 edges and 1 on the 33rd cycle. All ports read 0 for every address, and `rd_pending` = 0.
- RUN: write 0xDEADBEEF to r5, then read r5 on both ports next cycle. Expect 0xDEADBEEF. With the bypass macro, expect it in the same cycle.
- Write 0x1234 to r0 with `ZERO_REG=1`, and reserve r0. Expect r0 to read 0 and `rd_pending` 0.
- Reserve r7, then `rd_pending` = 1 on a port addressing r7. Write r7 = 0x55 and expect pending 0 next cycle. Reserve and write r9 in the same cycle and expect pending to stay 1 with data 0x55 written.
- During INIT: pulse `we` to r3 with 0xFFFF and `rsv_en` r3. After `ready`, expect r3 = 0 and not pending.
- In RUN: write r4 = 0xA, assert `clear` for 1 cycle. Expect `ready` to drop at once and r4 = 0 after re-init, with init again lasting NREGS edges. Repeat with NREGS=8, NRD=3, XLEN=64.
